lsu_split_unit: RTL
===================

Name: lsu_split_unit

Overview:
Parametrised load/store unit that replaces the purely combinational store/load alignment path of the single-cycle datapath. It sits between the core's execute stage and the data memory bus. It accepts one access at a time over a valid/ready handshake, aligns data and sign- or zero-extends it, and generates byte masks. Accesses that cross a bus-word boundary are split into two bus beats, or are flagged as misaligned when splitting is disabled.

Parameters:
XLEN, 32, data and address width; legal values are 32 or 64. NB = XLEN/8 bytes per bus word.
MISALIGNED_EN, 1, 1 = split boundary-crossing accesses into two beats; 0 = reject them with rsp_err.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  core access request.
req_ready  out  1  unit can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
req_unsigned  in  1  loads only: zero-extend instead of sign-extend.
req_addr  in  XLEN  byte address.
req_wdata  in  XLEN  store data, right-justified.
rsp_valid  out  1  one-cycle completion pulse.
rsp_err  out  1  valid with rsp_valid: access rejected.
rsp_rdata  out  XLEN  extended load data; 0 for stores and for errors.
mem_valid  out  1  bus beat request.
mem_ready  in  1  bus beat accepted; read data is valid in the same cycle.
mem_we  out  1  beat is a write.
mem_addr  out  XLEN  NB-aligned beat address.
mem_wdata  out  XLEN  beat write data.
mem_wmask  out  NB  beat byte enables; all zero on reads.
mem_rdata  in  XLEN  beat read data.

Behaviour:
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- Reset:
  - state goes to IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch we, size, unsigned, addr, wdata.
  - Compute off = addr mod NB and bytes = 1<<size.
  - Compute cross = (off + bytes > NB).
  - If the access is illegal, go to RESP with the error flag set. Illegal means size=3 with XLEN=32, or cross with MISALIGNED_EN=0.
  - Otherwise go to BEAT0.
- BEAT0:
  - mem_valid=1, mem_addr = addr & ~(NB-1).
  - Outputs are held stable until mem_ready.
  - On mem_ready, capture mem_rdata into lo, then go to BEAT1 if cross, else RESP.
- BEAT1:
  - mem_valid=1, mem_addr = beat0 address + NB, wrapping modulo 2^XLEN.
  - On mem_ready, capture mem_rdata into hi, then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then go to IDLE.
  - req_ready=0 in BEAT0, BEAT1 and RESP; req_valid is ignored in those states.
  - The earliest next acceptance is the cycle after RESP.
- Store alignment:
  - W = req_wdata zero-extended to 2*XLEN, shifted left by off*8.
  - M = ((1<<bytes)-1) shifted left by off, NB*2 bits wide.
  - BEAT0 drives the low halves of W and M; BEAT1 drives the high halves.
- Load alignment:
  - D = {hi, lo} >> off*8, with hi=0 if there is no second beat.
  - Keep the low `bytes` bytes, then sign-extend (req_unsigned=0) or zero-extend.
  - For XLEN=32, word loads ignore req_unsigned.
- Latency with zero bus wait states:
  - Aligned access: accept in cycle N, mem_valid in N+1, rsp_valid in N+2.
  - Split access: rsp_valid in N+3.
  - Illegal access: rsp_valid in N+1, and mem_valid never asserts.
- mem_ready is ignored outside BEAT0 and BEAT1.
- Reset during a beat:
  - mem_valid drops on the next edge.
  - Any partial store is not completed and the pending response is discarded.
  - The memory side must be reset together with this unit.
- A store whose first beat has been accepted always issues its second beat; there is no abort.

Test Plan:
- XLEN=32, LW at 0x100, mem_ready tied 1, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_wmask=0000, rsp_valid exactly 2 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
- LB at 0x103 with mem_rdata=0x80112233 -> rsp_rdata=0xFFFFFF80. The same request with req_unsigned=1 -> rsp_rdata=0x00000080.
- Split LW at 0x102, beat0 at 0x100 returning 0x33221100, beat1 at 0x104 returning 0x77665544 -> rsp_rdata=0x55443322, rsp_valid 3 cycles after acceptance.
- Split SH at 0x103 with wdata=0x0000ABCD -> beat0 at 0x100 with mask 1000 and wdata[31:24]=0xCD; beat1 at 0x104 with mask 0001 and wdata[7:0]=0xAB. Response: rsp_err=0, rsp_rdata=0.
- Hold mem_ready=0 for 5 cycles during BEAT0 while toggling req_valid -> mem_addr, mem_wdata and mem_wmask stay stable, req_ready stays 0, and no second request is accepted.
- Illegal accesses:
  - MISALIGNED_EN=0, LW at 0x101 -> no mem_valid, rsp_valid+rsp_err 1 cycle after acceptance.
  - XLEN=32 with size=3 -> the same error response.
- Reset mid-split: assert reset in BEAT1 -> the next cycle has mem_valid=0, req_ready=1, and no rsp_valid.

Source files
------------

// File: rtl/lsu_split_unit.sv
// lsu_split_unit: load/store unit between execute stage and data bus.
// Accepts one access at a time, aligns store data / byte enables, extends
// load data, and splits bus-word-crossing accesses into two beats (or
// rejects them when MISALIGNED_EN=0).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         core request handshake
//   req_we/size/unsigned        access type (size: 0=B,1=H,2=W,3=D)
//   req_addr/req_wdata          byte address, right-justified store data
//   rsp_valid/rsp_err/rsp_rdata one-cycle completion, error, load data
//   mem_valid/mem_ready         bus beat handshake
//   mem_we/addr/wdata/wmask     beat attributes (addr NB-aligned)
//   mem_rdata                   beat read data, valid with mem_ready
module lsu_split_unit #(
    parameter int unsigned XLEN          = 32,
    parameter bit          MISALIGNED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic            rsp_err,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic [XLEN-1:0] mem_rdata
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t          r_state, w_state_nx;
    logic            r_we, r_uns, r_cross;
    logic [1:0]      r_size;
    logic [OW-1:0]   r_off;
    logic [XLEN-1:0] r_base, r_w_hi, r_lo;
    logic [NB-1:0]   r_m_hi;

    logic            r_req_ready, r_rsp_valid, r_rsp_err, r_mem_valid, r_mem_we;
    logic [XLEN-1:0] r_rsp_rdata, r_mem_addr, r_mem_wdata;
    logic [NB-1:0]   r_mem_wmask;

    logic            w_req_ready_nx, w_rsp_valid_nx, w_rsp_err_nx, w_mem_valid_nx, w_mem_we_nx;
    logic [XLEN-1:0] w_rsp_rdata_nx, w_mem_addr_nx, w_mem_wdata_nx;
    logic [NB-1:0]   w_mem_wmask_nx;
    logic            w_accept, w_beat0_done;

    // Request-side decode: offset, crossing, legality, aligned store data/mask
    logic [OW-1:0]     w_off;
    logic [3:0]        w_bytes;
    logic              w_cross, w_illegal;
    logic [2*XLEN-1:0] w_wide;
    logic [2*NB-1:0]   w_mask;
    logic [XLEN-1:0]   w_base_req;

    always_comb begin
        w_off      = req_addr[OW-1:0];
        w_bytes    = 4'(1) << req_size;
        w_cross    = (5'(w_off) + 5'(w_bytes)) > 5'(NB);
        w_illegal  = ((req_size == 2'd3) && (XLEN == 32)) || (w_cross && !MISALIGNED_EN);
        w_wide     = (2*XLEN)'(req_wdata) << {w_off, 3'b000};
        w_mask     = (((2*NB)'(1) << w_bytes) - (2*NB)'(1)) << w_off;
        w_base_req = req_addr & ~XLEN'(NB - 1);
    end

    // Load extraction: shift the beat pair down, keep `bytes` bytes, extend.
    // The top-bit mask (keep ^ keep>>1) picks the sign bit without a variable index.
    logic [2*XLEN-1:0] w_pair;
    logic [XLEN-1:0]   w_d, w_keep, w_top, w_ext;
    logic              w_sign;

    always_comb begin
        w_pair = (r_state == BEAT1) ? {mem_rdata, r_lo} : {XLEN'(0), mem_rdata};
        w_d    = XLEN'(w_pair >> {r_off, 3'b000});
        w_keep = XLEN'((64'(1) << (7'(8) << r_size)) - 64'(1));
        w_top  = w_keep ^ (w_keep >> 1);
        w_sign = !r_uns && (|(w_d & w_top));
        w_ext  = (w_d & w_keep) | (w_sign ? ~w_keep : '0);
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nx     = r_state;
        w_req_ready_nx = r_req_ready;
        w_rsp_valid_nx = 1'b0;
        w_rsp_err_nx   = r_rsp_err;
        w_rsp_rdata_nx = r_rsp_rdata;
        w_mem_valid_nx = r_mem_valid;
        w_mem_we_nx    = r_mem_we;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        w_mem_wmask_nx = r_mem_wmask;
        w_accept       = 1'b0;
        w_beat0_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept       = 1'b1;
                    w_req_ready_nx = 1'b0;
                    if (w_illegal) begin
                        w_state_nx     = RESP;
                        w_rsp_valid_nx = 1'b1;
                        w_rsp_err_nx   = 1'b1;
                        w_rsp_rdata_nx = '0;
                    end else begin
                        w_state_nx     = BEAT0;
                        w_mem_valid_nx = 1'b1;
                        w_mem_we_nx    = req_we;
                        w_mem_addr_nx  = w_base_req;
                        w_mem_wdata_nx = w_wide[XLEN-1:0];
                        w_mem_wmask_nx = req_we ? w_mask[NB-1:0] : '0;
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    w_beat0_done = 1'b1;
                    if (r_cross) begin
                        w_state_nx     = BEAT1;
                        w_mem_addr_nx  = r_base + XLEN'(NB);
                        w_mem_wdata_nx = r_w_hi;
                        w_mem_wmask_nx = r_m_hi;
                    end else begin
                        w_state_nx     = RESP;
                        w_mem_valid_nx = 1'b0;
                        w_rsp_valid_nx = 1'b1;
                        w_rsp_err_nx   = 1'b0;
                        w_rsp_rdata_nx = r_we ? '0 : w_ext;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    w_state_nx     = RESP;
                    w_mem_valid_nx = 1'b0;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_err_nx   = 1'b0;
                    w_rsp_rdata_nx = r_we ? '0 : w_ext;
                end
            end
            RESP: begin
                w_state_nx     = IDLE;
                w_req_ready_nx = 1'b1;
                w_rsp_err_nx   = 1'b0;
                w_rsp_rdata_nx = '0;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State, output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_cross     <= 1'b0;
            r_size      <= '0;
            r_off       <= '0;
            r_base      <= '0;
            r_w_hi      <= '0;
            r_m_hi      <= '0;
            r_lo        <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_req_ready <= w_req_ready_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_err   <= w_rsp_err_nx;
            r_rsp_rdata <= w_rsp_rdata_nx;
            r_mem_valid <= w_mem_valid_nx;
            r_mem_we    <= w_mem_we_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_wdata <= w_mem_wdata_nx;
            r_mem_wmask <= w_mem_wmask_nx;
            if (w_accept) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_cross <= w_cross;
                r_size  <= req_size;
                r_off   <= w_off;
                r_base  <= w_base_req;
                r_w_hi  <= w_wide[2*XLEN-1:XLEN];
                r_m_hi  <= req_we ? w_mask[2*NB-1:NB] : '0;
            end
            if (w_beat0_done) begin
                r_lo <= mem_rdata;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;

endmodule
